// File: rtl/dcache_mem_ctrl_pkg.sv
// Shared types and address-field geometry for the MEM-stage data cache.
package dcache_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int WORDS   = 8;
    localparam int OFF_W   = 3;
    localparam int OFF_LSB = 1;
    localparam int IDX_LSB = OFF_LSB + OFF_W;

    function automatic int tag_width(input int idx_w);
        return ADDR_W - IDX_LSB - idx_w;
    endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Valid/dirty/tag arrays for the direct-mapped cache: one lookup port plus fill and dirty-set updates.
// Valid and dirty clear asynchronously on reset; the tag array keeps its contents.
module dcache_tag_store
    import dcache_mem_ctrl_pkg::*;
#(
    parameter int LINES = 32,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = tag_width(IDX_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             lk_hit,
    output logic             lk_valid,
    output logic             lk_dirty,
    output logic [TAG_W-1:0] lk_stored_tag,
    input  logic             upd_dirty,
    input  logic             upd_fill,
    input  logic [TAG_W-1:0] upd_tag
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_arr [LINES];

    assign lk_valid      = valid_q[idx];
    assign lk_dirty      = dirty_q[idx];
    assign lk_stored_tag = tag_arr[idx];
    assign lk_hit        = valid_q[idx] && (tag_arr[idx] == lk_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (upd_fill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (upd_dirty) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_fill)
            tag_arr[idx] <= upd_tag;
    end

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Direct-mapped write-back/write-allocate data cache for the MEM stage with a word-serial
// writeback/fill FSM; hits complete in the request cycle, misses raise stall until refilled.
module dcache_mem_ctrl #(
    parameter int LINES = 32,
    parameter int WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        stall,
    output logic        mm_req,
    output logic        mm_we,
    output logic [15:0] mm_addr,
    output logic [15:0] mm_wdata,
    input  logic [15:0] mm_rdata,
    input  logic        mm_ack,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    import dcache_mem_ctrl_pkg::*;

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = tag_width(IDX_W);

    state_t state_q, state_d;

    logic [OFF_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data_arr [LINES][WORDS];

    logic [OFF_W-1:0] a_off;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic             unused_addr_lsb;

    assign a_off           = addr[IDX_LSB-1:OFF_LSB];
    assign a_idx           = addr[IDX_W+IDX_LSB-1:IDX_LSB];
    assign a_tag           = addr[ADDR_W-1:IDX_W+IDX_LSB];
    assign unused_addr_lsb = addr[0];

    logic             req, hit, idle, miss_start, last_ack;
    logic [IDX_W-1:0] ts_idx;
    logic             ts_hit, ts_valid, ts_dirty;
    logic [TAG_W-1:0] ts_tag;

    logic             upd_dirty, upd_fill;
    logic             data_we;
    logic [IDX_W-1:0] data_widx;
    logic [OFF_W-1:0] data_woff;
    logic [15:0]      data_wdat;

    assign req        = mem_read | mem_write;
    assign idle       = (state_q == ST_IDLE);
    // Once a miss is in flight the line index comes from the latched request, not the bus.
    assign ts_idx     = idle ? a_idx : idx_q;
    assign hit        = req && ts_hit;
    assign miss_start = idle && req && !hit;
    assign last_ack   = mm_ack && (cnt_q == OFF_W'(WORDS - 1));
    assign stall      = !idle || (req && !hit);

    dcache_tag_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_store (
        .clk           (clk),
        .rst           (rst),
        .idx           (ts_idx),
        .lk_tag        (a_tag),
        .lk_hit        (ts_hit),
        .lk_valid      (ts_valid),
        .lk_dirty      (ts_dirty),
        .lk_stored_tag (ts_tag),
        .upd_dirty     (upd_dirty),
        .upd_fill      (upd_fill),
        .upd_tag       (tag_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (miss_start) state_d = (ts_valid && ts_dirty) ? ST_WB : ST_FILL;
            ST_WB:   if (last_ack)   state_d = ST_FILL;
            ST_FILL: if (last_ack)   state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mm_req    = 1'b0;
        mm_we     = 1'b0;
        mm_addr   = '0;
        mm_wdata  = '0;
        rdata     = '0;
        upd_dirty = 1'b0;
        upd_fill  = 1'b0;
        data_we   = 1'b0;
        data_widx = a_idx;
        data_woff = a_off;
        data_wdat = wdata;
        unique case (state_q)
            ST_IDLE: begin
                if (hit && mem_read)
                    rdata = data_arr[a_idx][a_off];
                if (hit && mem_write) begin
                    upd_dirty = 1'b1;
                    data_we   = 1'b1;
                end
            end
            ST_WB: begin
                mm_req   = 1'b1;
                mm_we    = 1'b1;
                mm_addr  = {ts_tag, idx_q, cnt_q, 1'b0};
                mm_wdata = data_arr[idx_q][cnt_q];
            end
            ST_FILL: begin
                mm_req    = 1'b1;
                mm_addr   = {tag_q, idx_q, cnt_q, 1'b0};
                upd_fill  = last_ack;
                data_we   = mm_ack;
                data_widx = idx_q;
                data_woff = cnt_q;
                data_wdat = mm_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            tag_q    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (miss_start) begin
                cnt_q <= '0;
                idx_q <= a_idx;
                tag_q <= a_tag;
                if (miss_cnt != 16'hFFFF)
                    miss_cnt <= miss_cnt + 16'd1;
            end else if (!idle && mm_ack) begin
                // Wraps 7 -> 0 on the final ack, which is exactly the reset needed between WB and FILL.
                cnt_q <= cnt_q + OFF_W'(1);
            end
            if (idle && hit && (hit_cnt != 16'hFFFF))
                hit_cnt <= hit_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we)
            data_arr[data_widx][data_woff] <= data_wdat;
    end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed scoreboard bench: stimulus pushes expected memory transactions and load data,
// a memory responder/monitor and a load monitor pop and compare as the DUT presents them.
module tb_dcache_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [15:0] addr, wdata, rdata;
    logic        stall, mm_req, mm_we, mm_ack;
    logic [15:0] mm_addr, mm_wdata, mm_rdata;
    logic [15:0] hit_cnt, miss_cnt;

    dcache_mem_ctrl #(.LINES(32), .WORDS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .mm_req   (mm_req),
        .mm_we    (mm_we),
        .mm_addr  (mm_addr),
        .mm_wdata (mm_wdata),
        .mm_rdata (mm_rdata),
        .mm_ack   (mm_ack),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
    } mm_exp_t;

    mm_exp_t     mm_q[$];
    logic [15:0] ld_q[$];
    logic [15:0] mem [0:32767];

    int checks = 0;
    int errors = 0;

    int   gap       = 0;
    int   wait_cnt  = 0;
    int   ack_total = 0;
    logic stray     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder and transaction monitor: decides acks at the falling edge so the DUT sees
    // them on the next rising edge, and checks each acked request against the expected queue.
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_we  = 1'b0;
    logic [15:0] prev_addr = '0;
    always @(negedge clk) begin
        logic    ack_n;
        mm_exp_t e;
        ack_n = 1'b0;
        if (mm_req && !rst) begin
            if (wait_cnt >= gap) begin
                ack_n    = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (mm_req && prev_req && !prev_ack) begin
            check("mm_addr_hold", 32'(mm_addr), 32'(prev_addr));
            check("mm_we_hold", 32'(mm_we), 32'(prev_we));
        end
        if (ack_n) begin
            ack_total++;
            if (mm_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mm_unexpected: got we=%0b addr=0x%0h, expected no transaction", mm_we, mm_addr);
            end else begin
                e = mm_q.pop_front();
                check("mm_we", 32'(mm_we), 32'(e.we));
                check("mm_addr", 32'(mm_addr), 32'(e.a));
                if (e.we)
                    check("mm_wdata", 32'(mm_wdata), 32'(e.d));
            end
            if (mm_we)
                mem[mm_addr[15:1]] = mm_wdata;
            else
                mm_rdata = mem[mm_addr[15:1]];
        end
        mm_ack    = ack_n | stray;
        prev_req  = mm_req;
        prev_ack  = ack_n;
        prev_addr = mm_addr;
        prev_we   = mm_we;
    end

    // Load monitor: a completed load is a read request that is not stalled.
    always @(negedge clk) begin
        if (!rst && mem_read && !mem_write && !stall) begin
            if (ld_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ld_unexpected: got rdata=0x%0h, expected no load", rdata);
            end else begin
                check("rdata", 32'(rdata), 32'(ld_q.pop_front()));
            end
        end
    end

    task automatic push_fill(input logic [15:0] base);
        for (int k = 0; k < 8; k++)
            mm_q.push_back('{we: 1'b0, a: base + 16'(2 * k), d: 16'h0});
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                         input int exp_stall);
        int n    = 0;
        bit done = 1'b0;
        @(posedge clk); #1;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (stall) n++;
            else       done = 1'b1;
        end
        check("req_completes", 32'(done), 32'd1);
        check("stall_cycles", 32'(n), 32'(exp_stall));
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        for (int i = 0; i < 32768; i++)
            mem[i] = 16'hA000 + 16'(i & 7);
        for (int k = 0; k < 8; k++)
            mem[(16'h3230 >> 1) + k] = 16'hC000 + 16'(k);

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; wdata = '0; mm_ack = 1'b0; mm_rdata = '0;
        #12;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mm_req", 32'(mm_req), 32'd0);
        check("rst_mm_addr", 32'(mm_addr), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Cold load: clean miss, 8 fills, then the held request hits.
        push_fill(16'h1230);
        ld_q.push_back(16'hA002);
        issue(1'b1, 1'b0, 16'h1234, 16'h0, 9);
        check("cold_miss_cnt", 32'(miss_cnt), 32'd1);
        check("cold_hit_cnt", 32'(hit_cnt), 32'd1);

        // Store hit then load back.
        issue(1'b0, 1'b1, 16'h1236, 16'hBEEF, 0);
        ld_q.push_back(16'hBEEF);
        issue(1'b1, 1'b0, 16'h1236, 16'h0, 0);
        check("store_hit_cnt", 32'(hit_cnt), 32'd3);

        // Conflict miss on the dirty line: writeback then fill.
        for (int k = 0; k < 8; k++)
            mm_q.push_back('{we: 1'b1, a: 16'h1230 + 16'(2 * k),
                             d: (k == 3) ? 16'hBEEF : 16'hA000 + 16'(k)});
        push_fill(16'h3230);
        ld_q.push_back(16'hC002);
        issue(1'b1, 1'b0, 16'h3234, 16'h0, 17);
        check("wb_miss_cnt", 32'(miss_cnt), 32'd2);
        check("wb_mem_beef", 32'(mem[16'h1236 >> 1]), 32'hBEEF);

        // Slow memory: 3 idle cycles before every ack.
        gap = 3;
        push_fill(16'h5670);
        ld_q.push_back(16'hA004);
        issue(1'b1, 1'b0, 16'h5678, 16'h0, 33);
        check("gap_miss_cnt", 32'(miss_cnt), 32'd3);
        check("gap_hit_cnt", 32'(hit_cnt), 32'd5);
        gap = 0;

        // Reset in the middle of a fill, after four words.
        push_fill(16'h0A40);
        @(posedge clk); #1;
        mem_read = 1'b1;
        addr     = 16'h0A40;
        base     = ack_total;
        for (int i = 0; i < 100 && ack_total < base + 4; i++)
            @(negedge clk);
        check("abort_reached_cnt4", 32'(ack_total - base), 32'd4);
        @(posedge clk); #2;
        rst      = 1'b1;
        mem_read = 1'b0;
        #1;
        check("abort_async_mm_req", 32'(mm_req), 32'd0);
        mm_q.delete();
        @(negedge clk);
        check("abort_mm_req", 32'(mm_req), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_miss_cnt", 32'(miss_cnt), 32'd0);
        check("abort_hit_cnt", 32'(hit_cnt), 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        stray = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stray = 1'b0;
        check("stray_mm_req", 32'(mm_req), 32'd0);
        check("stray_stall", 32'(stall), 32'd0);
        check("stray_miss_cnt", 32'(miss_cnt), 32'd0);
        push_fill(16'h0A40);
        ld_q.push_back(16'hA000);
        issue(1'b1, 1'b0, 16'h0A40, 16'h0, 9);
        check("reload_miss_cnt", 32'(miss_cnt), 32'd1);

        // Read and write together act as a store.
        push_fill(16'h0010);
        issue(1'b1, 1'b1, 16'h0010, 16'h5555, 9);
        ld_q.push_back(16'h5555);
        issue(1'b1, 1'b0, 16'h0010, 16'h0, 0);
        check("rw_miss_cnt", 32'(miss_cnt), 32'd2);
        check("rw_hit_cnt", 32'(hit_cnt), 32'd3);

        repeat (3) @(posedge clk);
        check("mm_q_drained", 32'(mm_q.size()), 32'd0);
        check("ld_q_drained", 32'(ld_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_mem_ctrl.md
Name: dcache_mem_ctrl

Overview:
Data-cache responder for MEM-stage requests driven by the EX/MEM pipeline register: mem_read/mem_write, address = ALU result, store data = forwarded rs2.
- Direct-mapped, write-back, write-allocate cache holding tag, valid, dirty and data arrays.
- Misses run a word-serial writeback/fill FSM against main memory.
- stall is the back-pressure to the pipeline: it drops the write enables of the PC, IF/ID, ID/EX and EX/MEM registers, and inserts a bubble into MEM/WB.

Parameters:
LINES, 32, number of cache lines (power of 2, at least 2); IDX_W = log2(LINES)
WORDS, 8, 16-bit words per line (fixed at 8; offset = addr[3:1])

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-high
mem_read  in  1  load request from EX/MEM
mem_write  in  1  store request from EX/MEM
addr  in  16  byte address; bit 0 ignored
wdata  in  16  store data
rdata  out  16  load data, combinational, valid when hit && mem_read
stall  out  1  hold pipeline this cycle
mm_req  out  1  main-memory request
mm_we  out  1  1 = write word, 0 = read word
mm_addr  out  16  word-aligned main-memory byte address
mm_wdata  out  16  writeback word
mm_rdata  in  16  fill word, valid on mm_ack when mm_we = 0
mm_ack  in  1  one-cycle completion of the current word
hit_cnt  out  16  saturating count of serviced hits
miss_cnt  out  16  saturating count of misses entered

Behaviour:
- Address split: offset = addr[3:1], index = addr[IDX_W+3:4], tag = addr[15:IDX_W+4].
- req = mem_read | mem_write. If both are set, treat as a write.
- hit = req && valid[index] && tag_arr[index] == tag.
- stall = (state != IDLE) || (req && !hit). Combinational, no added latency.
- States:
  - IDLE: on hit, loads return rdata the same cycle. Stores write data[index][offset] and set dirty[index] at the clock edge. On req && !hit, go to WB if valid && dirty, else FILL. Clear cnt and increment miss_cnt.
  - WB: mm_req = 1, mm_we = 1, mm_addr = {victim tag, index, cnt, 1'b0}, mm_wdata = data[index][cnt]. On mm_ack: cnt++. On the ack with cnt = 7, clear cnt and go to FILL.
  - FILL: mm_req = 1, mm_we = 0, mm_addr = {req tag, index, cnt, 1'b0}. On mm_ack: write data[index][cnt] = mm_rdata, cnt++. On the ack with cnt = 7, set valid = 1, dirty = 0, tag_arr = tag, and go to IDLE.
- The stalled request is still presented in IDLE after FILL, so it then hits. Total miss penalty is 8 (clean) or 16 (dirty) acks plus 1 cycle.
- mm_req stays high continuously across words. Address and data change only in the cycle after an ack.
- mm_req = 0 in IDLE. mm_ack in IDLE is ignored.
- The address changing during WB/FILL is illegal, since the pipeline is stalled. The FSM uses the index/tag latched on miss entry.
- hit_cnt increments once per IDLE hit cycle. Both counters saturate at 0xFFFF.
- Reset (any time, including mid-WB/FILL):
  - state = IDLE, cnt = 0.
  - All valid and dirty bits = 0; the data and tag arrays are not reset.
  - mm_req = 0, mm_we = 0, mm_addr = 0, mm_wdata = 0.
  - hit_cnt = miss_cnt = 0.
  - stall = 0 with no request; rdata = 0 on a miss or with no request.
  - The partial transaction is abandoned. A late mm_ack is ignored.

Decomposition:
- Shared package: state encoding (IDLE, WB, FILL), offset/index/tag field widths, and the WORDS constant.
- One natural sub-module, dcache_tag_store: valid/dirty/tag arrays with async-clear valid/dirty, lookup compare and an update port. The data array and FSM stay in dcache_mem_ctrl.

Test Plan:
- Cold load addr 0x1234 with memory returning 0xA000+word, ack every cycle → stall high 9 cycles; mm_addr sequence 0x1230, 0x1232, …, 0x123E; then rdata = 0xA002, stall = 0, miss_cnt = 1, hit_cnt = 1.
- Store 0xBEEF to 0x1236 after the fill → no stall, same-cycle completion; a following load of 0x1236 returns 0xBEEF.
- Load 0x3234 (same index, different tag) after the dirty store → 8 writes with mm_we = 1 at 0x1230…0x123E, the 0x1236 write carrying 0xBEEF, then 8 reads at 0x3230…; stall for 17 cycles.
- Memory ack with 3-cycle gaps → mm_addr and mm_req held stable between acks; only ack cycles advance cnt; 8 fills complete.
- rst asserted mid-FILL at cnt = 4 → next cycle mm_req = 0, stall = 0 with no request; a reload of the same address misses again; a stray mm_ack has no effect.
- mem_read = mem_write = 1 at 0x0010 with data 0x5555 → treated as a store; a later load returns 0x5555.
